// File: rtl/fb_fifo_arbiter.sv
// fb_fifo_arbiter: round-robin burst arbiter sharing one frame-buffer FIFO
// write port among N requesters. A grant is held for up to BURST_LEN beats
// or until the owner marks a beat with last, so DDR3 write bursts stay
// contiguous per source. fifo_full stalls the owner without losing data.
//
// Optional feature: define FB_ARB_WATCHDOG_EN to release a grant whose owner
// has been idle (valid low) for TIMEOUT consecutive cycles. When the macro is
// undefined, timeout_pulse is tied low and an idle owner keeps the grant.

module fb_fifo_arbiter #(
    parameter int N         = 4,
    parameter int WIDTH     = 512,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 16,
    localparam int GW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               preset_full,
    input  logic [N-1:0]       req_valid,
    input  logic [N*WIDTH-1:0] req_data,
    input  logic [N-1:0]       req_last,
    output logic [N-1:0]       req_ready,
    output logic [WIDTH-1:0]   fifo_data,
    output logic               fifo_write_en,
    input  logic               fifo_full,
    output logic [GW-1:0]      grant_id,
    output logic               busy,
    output logic               timeout_pulse
);

    // Beat counter only has to reach BURST_LEN-1 before the grant is released.
    localparam int            BW        = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state;
    logic [GW-1:0] last_owner;
    logic [BW-1:0] beat_cnt;

    logic          owner_valid;
    logic          owner_last;
    logic          any_valid;
    logic [GW-1:0] next_owner;
    logic          transfer;
    logic          burst_done;
    logic          wd_fire;
    logic          release_grant;

    // Select the current owner's valid/last/data; fifo_data follows the owner
    // slice even on cycles without a write.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        fifo_data   = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_id == GW'(i)) begin
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
                fifo_data   = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Round-robin pick: first valid index strictly after last_owner, modulo N.
    // Loops are fully unrolled so every index is a constant.
    always_comb begin
        any_valid  = |req_valid;
        next_owner = grant_id;
        for (int lo = 0; lo < N; lo++) begin
            if (last_owner == GW'(lo)) begin
                // Walk from farthest to nearest so the nearest valid wins.
                for (int k = N; k >= 1; k--) begin
                    if (req_valid[(lo + k) % N]) begin
                        next_owner = GW'((lo + k) % N);
                    end
                end
            end
        end
    end

    // Write path is combinational so a full FIFO blocks the write in the same
    // cycle it is flagged.
    assign transfer      = (state == BURST) && owner_valid && !fifo_full;
    assign fifo_write_en = transfer;
    assign burst_done    = transfer && (owner_last || (beat_cnt == LAST_BEAT));
    assign release_grant = burst_done || wd_fire;

    // Only the owner sees ready, and only while the FIFO can accept a beat.
    always_comb begin
        req_ready = '0;
        if ((state == BURST) && !fifo_full) begin
            for (int i = 0; i < N; i++) begin
                if (grant_id == GW'(i)) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    // Arbitration FSM: grant in IDLE, count beats in BURST, release on last,
    // burst length, or watchdog. Reset leaves requester 0 first in line.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge preset_full) begin
        if (preset_full) begin
            state      <= IDLE;
            last_owner <= GW'(N - 1);
            grant_id   <= '0;
            beat_cnt   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_id <= next_owner;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (release_grant) begin
                        last_owner <= grant_id;
                        beat_cnt   <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (transfer) begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FB_ARB_WATCHDOG_EN
    localparam int            IW        = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    logic [IW-1:0] idle_cnt;

    // Fires on the TIMEOUT-th consecutive cycle the owner has valid low; a
    // stall with valid high is not idleness.
    assign wd_fire = (state == BURST) && !owner_valid && (idle_cnt == IDLE_LAST);

    // Idle counter and one-cycle release pulse.
    always_ff @(posedge clk or posedge preset_full) begin
        if (preset_full) begin
            idle_cnt      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= wd_fire;
            if ((state != BURST) || owner_valid || wd_fire) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + IW'(1);
            end
        end
    end
`else
    // Watchdog compiled out: an idle owner keeps its grant indefinitely.
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT > 0);
    assign wd_fire            = 1'b0;
    assign timeout_pulse      = 1'b0;
`endif

endmodule

// File: doc/fb_fifo_arbiter.md
# fb_fifo_arbiter

Round-robin burst arbiter that shares one frame-buffer single-clock FIFO write port among N pixel/packet requesters in the DDR3 frame-buffer path. A requester holds the grant for up to BURST_LEN beats, or until it marks a beat with last. Holding the grant keeps DDR3 write bursts contiguous per source. Back-pressure from the FIFO's full flag stalls the granted requester without losing data.

## Interface
- N, 4: number of requesters (≥1)
- WIDTH, 512: data width, matches FIFO WIDTH
- BURST_LEN, 8: max beats per grant (≥1)
- TIMEOUT, 16: idle cycles before forced release (used only with watchdog)

- clk  in  1  clock; all state on rising edge
- preset_full  in  1  reset, asynchronous, active-high
- req_valid  in  N  requester i has a beat
- req_data  in  N*WIDTH  requester i data in slice [i*WIDTH +: WIDTH]
- req_last  in  N  beat is last of requester i's packet
- req_ready  out  N  one-hot accept; beat transfers when valid&ready
- fifo_data  out  WIDTH  to FIFO i_data_in
- fifo_write_en  out  1  to FIFO i_write_en
- fifo_full  in  1  from FIFO i_full_out
- grant_id  out  $clog2(N) (min 1)  current/last owner
- busy  out  1  high in BURST state
- timeout_pulse  out  1  one-cycle pulse on watchdog release (0 when macro off)

## Operation
- States: IDLE, BURST.
- IDLE: req_ready=0. If any req_valid, pick first valid index after last_owner (modulo N). Register owner into grant_id, clear beat_cnt, go BURST. Otherwise stay.
- BURST: req_ready[owner] = ~fifo_full; other bits 0.
  - Transfer = req_valid[owner] & ~fifo_full.
  - fifo_write_en = transfer; fifo_data = req_data[owner] (combinational mux; fifo_data = owner slice even when not writing).
  - On transfer, beat_cnt++.
  - Release to IDLE when a transfer occurs with req_last[owner]=1 or beat_cnt+1==BURST_LEN. On release, last_owner <= owner.
- beat_cnt width $clog2(BURST_LEN+1); never exceeds BURST_LEN-1 while in BURST.
- Non-owner requesters see ready=0 and must hold valid/data (AXI-style; no drop).
- fifo_full high: stall, no write, no beat count. Grant is kept.
- Requester drops valid mid-burst: grant is kept (watchdog aside).
- last and BURST_LEN boundary on same beat: single release.
- N=1: same requester is re-granted after every release.

## Timing
- Reset values: state IDLE, last_owner=N-1 (requester 0 wins first), grant_id=0, beat_cnt=0, req_ready=0, fifo_write_en=0, busy=0, timeout_pulse=0.
- Reset is async. Assertion mid-burst aborts immediately. No write occurs during reset, and the partial burst is not resumed.
- Arbitration latency: valid seen in IDLE at cycle t gives grant in t+1. First write is possible in cycle t+1.
- One IDLE bubble cycle between consecutive grants. Max throughput is BURST_LEN/(BURST_LEN+1).
- Write path is combinational from req_valid/fifo_full to fifo_write_en, so it tracks fifo_full in the same cycle. The FIFO never sees a write while full.

## Configuration
- FB_ARB_WATCHDOG_EN defined:
  - In BURST, an idle counter increments each cycle that req_valid[owner]=0 and resets on any cycle with valid=1.
  - On reaching TIMEOUT, release to IDLE, rotate last_owner, and pulse timeout_pulse for 1 cycle.
  - fifo_full stalls with valid=1 never count.
- Not defined: no idle counter. timeout_pulse is tied 0, and an idle owner holds the grant indefinitely.

## Test plan
- Reset, then req_valid=4'b1111 with no last: grants go 0,1,2,3,0, each 8 writes. grant_id changes every 9 cycles, and fifo_write_en is low exactly 1 cycle between bursts.
- Requester 2 sends 3 beats (0xA,0xB,0xC) with last on 0xC: exactly 3 writes in order, then IDLE. A later-pending requester 3 is granted next.
- fifo_full held high 5 cycles mid-burst after beat 4: fifo_write_en=0 and req_ready=0 for those 5 cycles. Beats 5–8 then follow; total beats per grant = 8.
- preset_full asserted after beat 3 of a burst: outputs zero asynchronously. After release, requester 0 wins first regardless of previous owner.
- FB_ARB_WATCHDOG_EN, TIMEOUT=16: owner 1 drops valid after 2 beats. Release occurs 16 cycles later with timeout_pulse high one cycle, then the grant moves to requester 2. Without the macro, owner 1 holds the grant indefinitely.
